// File: rtl/seq_divider_cla.sv
// Sequential unsigned restoring divider. Each RUN cycle performs one trial
// subtraction (shifted remainder + ~divisor + 1) on a chain of 4-bit CLA
// slices. The chain's final carry-out is the not-borrow / quotient bit.

// One 4-bit carry-lookahead slice with fully expanded carries.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

module seq_divider_cla #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int NSL = WIDTH / 4;
  localparam int CW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] shifted, dvs_n, trial, rem_nxt, quo_nxt;
  logic [NSL:0]     carry;
  logic             no_borrow, last_iter;

  // Trial subtraction: shifted + ~dvs + 1, carry-in of 1 into slice 0.
  assign shifted  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign dvs_n    = ~dvs;
  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < NSL; i++) begin : g_sl
      cla4 u_cla (
        .a   (shifted[4*i +: 4]),
        .b   (dvs_n[4*i +: 4]),
        .cin (carry[i]),
        .sum (trial[4*i +: 4]),
        .cout(carry[i+1])
      );
    end
  endgenerate

  assign no_borrow = carry[NSL];
  assign rem_nxt   = no_borrow ? trial : shifted;
  assign quo_nxt   = {quo[WIDTH-2:0], no_borrow};
  assign last_iter = (cnt == CW'(1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: divide-by-zero skips RUN; DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one restoring step per RUN cycle,
  // result registers updated only at the end so they hold between runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            quo         <= dividend;
            rem         <= '0;
            dvs         <= divisor;
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            quotient  <= quo_nxt;
            remainder <= rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_cla.sv
// Self-checking bench for seq_divider_cla (WIDTH=8) against a plain
// arithmetic model (/ and %).
module tb_seq_divider_cla;
  localparam int W = 8;

  logic         clk = 0, rst = 0, start = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0, n_err = 0;

  seq_divider_cla #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Present a request for exactly one accepting edge, then drop start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 0;
  endtask

  // Count negedges after the accept edge until done; n=0 on timeout.
  task automatic wait_done(output int n, output int nbusy, output bit overlap);
    n = 0; nbusy = 0; overlap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && done) overlap = 1;
      if (done) begin n = k; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1; #3;
    n_cmp++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_basic;
    int n, nb; bit ov;
    issue(100, 7);
    wait_done(n, nb, ov);
    n_cmp++; if (n !== W + 1) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", n, W + 1); end
    n_cmp++; if (nb !== W) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, W); end
    n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL basic_busy_done_overlap: got %b want 0", ov); end
    n_cmp++; if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0",
                        quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] av[4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [W-1:0] bv[4] = '{8'd1, 8'd9, 8'd255, 8'd3};
    int n, nb; bit ov;
    for (int k = 0; k < 4; k++) begin
      issue(av[k], bv[k]);
      wait_done(n, nb, ov);
      n_cmp++;
      if (n !== W + 1 || quotient !== av[k] / bv[k] || remainder !== av[k] % bv[k]) begin
        n_err++;
        $display("FAIL b2b_%0d/%0d: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                 av[k], bv[k], n, quotient, remainder, W + 1, av[k] / bv[k], av[k] % bv[k]);
      end
    end
  endtask

  task automatic test_div_zero;
    int n, nb; bit ov;
    issue(77, 0);
    wait_done(n, nb, ov);
    n_cmp++; if (n !== 1 || nb !== 0) begin
      n_err++; $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d want lat=1 busy_cycles=0", n, nb);
    end
    n_cmp++; if (quotient !== 8'd255 || remainder !== 8'd77 || div_by_zero !== 1'b1) begin
      n_err++; $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=77 dbz=1",
                        quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_cmp++; if (div_by_zero !== 1'b1 || quotient !== 8'd255) begin
      n_err++; $display("FAIL dbz_hold: got q=%0d dbz=%b want q=255 dbz=1", quotient, div_by_zero);
    end
    issue(77, 7);
    wait_done(n, nb, ov);
    n_cmp++; if (n !== W + 1 || quotient !== 8'd11 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL after_dbz: got lat=%0d q=%0d r=%0d dbz=%b want lat=%0d q=11 r=0 dbz=0",
                        n, quotient, remainder, div_by_zero, W + 1);
    end
  endtask

  task automatic test_ignored_start;
    int n = 0, extra = 0;
    issue(200, 13);
    for (int k = 1; k <= 40 && n == 0; k++) begin
      @(negedge clk);
      if (done) n = k;
      if (k == 4) begin start = 1; dividend = 9; divisor = 3; end
      if (k == 5) start = 0;
    end
    n_cmp++; if (n !== W + 1 || quotient !== 8'd15 || remainder !== 8'd5) begin
      n_err++; $display("FAIL ignored_start_result: got lat=%0d q=%0d r=%0d want lat=%0d q=15 r=5",
                        n, quotient, remainder, W + 1);
    end
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_cmp++; if (extra !== 0) begin
      n_err++; $display("FAIL ignored_start_no_second_run: got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int n, nb, seen = 0; bit ov;
    issue(200, 13);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    rst = 1; #1;
    n_cmp++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (done) seen++; end
    rst = 0;
    for (int k = 0; k < W + 2; k++) begin @(negedge clk); if (done || busy) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL reset_mid_no_done: got %0d want 0", seen); end
    issue(200, 13);
    wait_done(n, nb, ov);
    n_cmp++; if (n !== W + 1 || quotient !== 8'd15 || remainder !== 8'd5) begin
      n_err++; $display("FAIL reset_mid_rerun: got lat=%0d q=%0d r=%0d want lat=%0d q=15 r=5",
                        n, quotient, remainder, W + 1);
    end
  endtask

  task automatic test_random;
    int n, nb, bad = 0; bit ov;
    logic [W-1:0] a, b;
    for (int k = 0; k < 1000; k++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      issue(a, b);
      wait_done(n, nb, ov);
      n_cmp++;
      if (n !== W + 1 || nb !== W || ov || quotient !== a / b || remainder !== a % b
          || int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
        n_err++; bad++;
        if (bad <= 10)
          $display("FAIL random_%0d/%0d: got lat=%0d q=%0d r=%0d want lat=%0d q=%0d r=%0d",
                   a, b, n, quotient, remainder, W + 1, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_div_zero;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_divider_cla.md
# seq_divider_cla

Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the 4-bit carry-lookahead adder. Each iteration computes a trial subtraction on a chain of 4-bit CLA slices: remainder + ~divisor with carry-in 1. The final carry-out serves as the not-borrow flag. It sits beside the adder datapath as the team's first sequential arithmetic unit, with a start/busy/done handshake.

## Interface
- WIDTH, 8: operand width in bits. Must be a multiple of 4, because the subtractor is built from WIDTH/4 chained 4-bit CLA slices.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request pulse; sampled only in IDLE.
- dividend  in  WIDTH  numerator; captured on the accepting edge.
- divisor  in  WIDTH  denominator; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; results valid in that cycle.
- quotient  out  WIDTH  result quotient.
- remainder  out  WIDTH  result remainder.
- div_by_zero  out  1  set when the accepted divisor was 0.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- **Reset:** state=IDLE. busy, done and div_by_zero are 0. quotient, remainder and the iteration counter are 0. All internal registers are 0.
- **IDLE + start=1, divisor≠0:**
  - Load the quotient shift register with dividend.
  - Set the partial remainder to 0 and the counter to WIDTH.
  - Clear div_by_zero.
  - Go to RUN.
- **IDLE + start=1, divisor=0:**
  - quotient = all ones.
  - remainder = dividend.
  - div_by_zero = 1.
  - Go directly to DONE.
- **RUN iteration (one per clock):**
  - Shift {rem, quo} left by 1, giving shifted remainder r' = {rem[WIDTH-2:0], quo[WIDTH-1]}.
  - Compute trial t = r' + ~divisor + 1 through the CLA slice chain, with cin=1 into slice 0.
  - Chain cout of each slice into cin of the next.
  - If the final carry-out is 1 (no borrow): rem ← t and the new quo LSB = 1.
  - Otherwise: rem ← r' and the new quo LSB = 0.
  - Decrement the counter.
- **RUN exit:** when the counter reaches 0 after the WIDTH-th iteration, go to DONE. quotient and remainder then present the final quo and rem.
- **DONE:** done=1 for exactly one cycle, then go to IDLE unconditionally.
- **Output hold:** quotient, remainder and div_by_zero hold their values until the next accepted start. They are not cleared on the DONE→IDLE transition.
- **Ignored start:** start in RUN or DONE is ignored and not queued.
- **Operand changes:** changes to dividend or divisor after the accepting edge have no effect.
- **Width rule:** the remainder register is WIDTH bits. r' is never ≥ 2·divisor, so no extra bit is needed, and the CLA carry-out carries the comparison.

## Timing
- Start accepted at edge t0. busy=1 from t0 for exactly WIDTH cycles, so busy is asserted through edge t0+WIDTH.
- Normal division:
  - State becomes DONE at edge t0+WIDTH.
  - done=1 in the cycle between edges t0+WIDTH and t0+WIDTH+1.
  - IDLE at t0+WIDTH+1.
  - The earliest next accepted start is edge t0+WIDTH+1.
  - Latency from the start edge to done is WIDTH cycles. With WIDTH=8, done rises 8 cycles after start.
- Divide-by-zero:
  - State becomes DONE at t0 and done=1 in the next cycle. busy is never asserted.
  - IDLE at t0+1.
- busy and done are never high together.
- **Reset mid-operation:** asserting rst in any state returns immediately (asynchronously) to the reset values above. No done pulse is produced for the aborted operation. Operation resumes from IDLE on the first edge after rst deasserts.
- **Combinational path:** the only combinational path is the CLA chain inside one RUN cycle. There is no input-to-output combinational path.

## Test plan
- Reset, then start with dividend=100 and divisor=7 (WIDTH=8) → busy for 8 cycles, done pulse 8 cycles after start, quotient=14, remainder=2, div_by_zero=0.
- Boundary operands, each back-to-back with start issued in the cycle after done:
  - 255/1 → q=255, r=0.
  - 5/9 → q=0, r=5.
  - 255/255 → q=1, r=0.
  - 0/3 → q=0, r=0.
- 77/0 → done one cycle after start, busy never high, quotient=255, remainder=77, div_by_zero=1. A following 77/7 → q=11, r=0 and div_by_zero=0.
- Start 200/13, then pulse start with 9/3 during cycle 4 of RUN → the second request is ignored, the result is q=15, r=5, and no second done appears.
- Start 200/13, assert rst during cycle 5 of RUN → all outputs 0 immediately and no done pulse. After release, 200/13 → q=15, r=5.
- Random sweep of 1000 pairs with divisor≠0 → quotient·divisor+remainder == dividend and remainder < divisor, checked at every done.
